// File: rtl/motor_drv_pkg.sv
// Shared types for the H-bridge gate driver.
//   hb_state_t : bridge sequencing FSM state, 3-bit encoding exported on state_o
//   leg_mode_t : per-leg drive mode selected by the FSM
package motor_drv_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DEAD    = 3'd1,
      RUN_FWD = 3'd2,
      RUN_REV = 3'd3,
      BRAKE   = 3'd4,
      FAULT   = 3'd5
   } hb_state_t;

   typedef enum logic [1:0] {
      OFF = 2'd0,
      PWM = 2'd1,
      LOW = 2'd2
   } leg_mode_t;

endpackage

// File: rtl/deadtime_leg.sv
// One half-bridge leg with dead-time insertion on every PWM transition.
//   ACLK, ARESET   : clock, asynchronous active-high reset
//   mode           : OFF (both gates off), PWM (follow pwm with dead time), LOW (low side on)
//   pwm            : PWM input, synchronous to ACLK
//   gate_h, gate_l : registered high/low gate drives, never both 1
module deadtime_leg
   import motor_drv_pkg::*;
#(
   parameter int unsigned DEAD_CYCLES = 10
) (
   input  logic      ACLK,
   input  logic      ARESET,
   input  leg_mode_t mode,
   input  logic      pwm,
   output logic      gate_h,
   output logic      gate_l
);

   localparam int unsigned CNT_W = $clog2(DEAD_CYCLES + 1);

   logic             pwm_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             gate_h_d, gate_l_d;

   always_comb begin
      cnt_d    = '0;
      gate_h_d = 1'b0;
      gate_l_d = 1'b0;
      unique case (mode)
         OFF: ;
         LOW: gate_l_d = 1'b1;
         PWM: begin
            if (pwm != pwm_q) begin
               // Edge (or re-edge during dead time): drop both and restart the interval.
               cnt_d = CNT_W'(DEAD_CYCLES);
            end else if (cnt_q > CNT_W'(1)) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               // Counter reaching zero (or already idle): drive the side pwm_q selects.
               gate_h_d = pwm_q;
               gate_l_d = ~pwm_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         pwm_q  <= 1'b0;
         cnt_q  <= '0;
         gate_h <= 1'b0;
         gate_l <= 1'b0;
      end else begin
         // pwm_q tracks the input in every mode so PWM entry needs no extra dead time.
         pwm_q  <= pwm;
         cnt_q  <= cnt_d;
         gate_h <= gate_h_d;
         gate_l <= gate_l_d;
      end
   end

endmodule

// File: rtl/hbridge_deadtime_driver.sv
// H-bridge gate driver: turns one PWM signal plus enable/dir/brake into four gate drives,
// sequencing direction/brake changes through an all-off interval and latching faults.
//   ACLK, ARESET            : clock, asynchronous active-high reset
//   enable, dir, brake      : bridge controls (dir 0 = leg A PWM, 1 = leg B PWM)
//   pwm_in                  : PWM from the generator, synchronous to ACLK
//   fault_n                 : asynchronous driver fault, active low
//   fault_clr               : pulse clearing a latched fault once fault_n is high
//   gate_ah/al/bh/bl        : registered gate drives
//   fault_latched, state_o  : fault flag and FSM state
module hbridge_deadtime_driver
   import motor_drv_pkg::*;
#(
   parameter int unsigned DEAD_CYCLES = 10
) (
   input  logic       ACLK,
   input  logic       ARESET,
   input  logic       enable,
   input  logic       dir,
   input  logic       brake,
   input  logic       pwm_in,
   input  logic       fault_n,
   input  logic       fault_clr,
   output logic       gate_ah,
   output logic       gate_al,
   output logic       gate_bh,
   output logic       gate_bl,
   output logic       fault_latched,
   output logic [2:0] state_o
);

   localparam int unsigned CNT_W = $clog2(DEAD_CYCLES + 1);

   hb_state_t        state_q, state_d;
   logic [CNT_W-1:0] dead_cnt_q, dead_cnt_d;
   logic             fault_meta_q, fault_sync_q;
   logic             fault_latched_q;
   leg_mode_t        mode_a, mode_b;

   // Sync flops reset to the no-fault level so reset release does not trip FAULT.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         fault_meta_q <= 1'b1;
         fault_sync_q <= 1'b1;
      end else begin
         fault_meta_q <= fault_n;
         fault_sync_q <= fault_meta_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      dead_cnt_d = '0;
      if (!fault_sync_q) begin
         state_d = FAULT;
      end else if (state_q == FAULT) begin
         if (fault_clr) state_d = IDLE;
      end else if (!enable) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    state_d = DEAD;
            DEAD: begin
               if (dead_cnt_q != '0) begin
                  dead_cnt_d = dead_cnt_q - CNT_W'(1);
               end else if (brake) begin
                  state_d = BRAKE;
               end else begin
                  state_d = dir ? RUN_REV : RUN_FWD;
               end
            end
            RUN_FWD: if (dir || brake) state_d = DEAD;
            RUN_REV: if (!dir || brake) state_d = DEAD;
            BRAKE:   if (!brake) state_d = DEAD;
            default: state_d = IDLE;
         endcase
      end
      // DEAD is held for DEAD_CYCLES cycles: counts DEAD_CYCLES-1 down to 0.
      if (state_d == DEAD && state_q != DEAD) dead_cnt_d = CNT_W'(DEAD_CYCLES - 1);
   end

   // Leg modes follow the next state so gates change on the same edge as state_o.
   always_comb begin
      mode_a = OFF;
      mode_b = OFF;
      unique case (state_d)
         RUN_FWD: begin mode_a = PWM; mode_b = LOW; end
         RUN_REV: begin mode_a = LOW; mode_b = PWM; end
         BRAKE:   begin mode_a = LOW; mode_b = LOW; end
         default: ;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q         <= IDLE;
         dead_cnt_q      <= '0;
         fault_latched_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         dead_cnt_q      <= dead_cnt_d;
         fault_latched_q <= (state_d == FAULT);
      end
   end

   assign fault_latched = fault_latched_q;
   assign state_o       = state_q;

   deadtime_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_a (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .mode   (mode_a),
      .pwm    (pwm_in),
      .gate_h (gate_ah),
      .gate_l (gate_al)
   );

   deadtime_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_b (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .mode   (mode_b),
      .pwm    (pwm_in),
      .gate_h (gate_bh),
      .gate_l (gate_bl)
   );

endmodule

// File: tb/tb_hbridge_deadtime_driver.sv
// Scoreboard bench for hbridge_deadtime_driver with DEAD_CYCLES=4.
// Stimulus runs on the falling edge and queues the expected output word
// {fault_latched, state_o, ah, al, bh, bl} for a target cycle; the monitor samples
// 1 unit after every rising edge and pops entries whose target cycle has arrived.
module tb_hbridge_deadtime_driver;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_DEAD = 3'd1;
   localparam logic [2:0] S_FWD  = 3'd2;
   localparam logic [2:0] S_REV  = 3'd3;
   localparam logic [2:0] S_BRK  = 3'd4;
   localparam logic [2:0] S_FLT  = 3'd5;

   logic       ACLK = 1'b0;
   logic       ARESET = 1'b1;
   logic       enable = 1'b0, dir = 1'b0, brake = 1'b0, pwm_in = 1'b0;
   logic       fault_n = 1'b1, fault_clr = 1'b0;
   logic       gate_ah, gate_al, gate_bh, gate_bl, fault_latched;
   logic [2:0] state_o;

   hbridge_deadtime_driver #(.DEAD_CYCLES(4)) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .enable        (enable),
      .dir           (dir),
      .brake         (brake),
      .pwm_in        (pwm_in),
      .fault_n       (fault_n),
      .fault_clr     (fault_clr),
      .gate_ah       (gate_ah),
      .gate_al       (gate_al),
      .gate_bh       (gate_bh),
      .gate_bl       (gate_bl),
      .fault_latched (fault_latched),
      .state_o       (state_o)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      int         tgt;
      string      nm;
      logic [7:0] v;
   } sb_item_t;

   sb_item_t sb[$];
   int       cyc = 0;
   int       checks = 0;
   int       failures = 0;
   logic     shoot_seen = 1'b0;

   function automatic logic [7:0] act_word();
      return {fault_latched, state_o, gate_ah, gate_al, gate_bh, gate_bl};
   endfunction

   task automatic compare(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Queue an expectation d cycles after the current one; gates are {ah,al,bh,bl}.
   task automatic expect_at(input int d, input string nm, input logic [2:0] st,
                            input logic [3:0] g, input logic fl);
      sb_item_t it;
      it.tgt = cyc + d;
      it.nm  = nm;
      it.v   = {fl, st, g};
      sb.push_back(it);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge ACLK);
   endtask

   // Monitor: pops every expectation due this cycle.
   initial begin
      sb_item_t it;
      forever begin
         @(posedge ACLK);
         #1;
         cyc++;
         while (sb.size() > 0 && sb[0].tgt <= cyc) begin
            it = sb.pop_front();
            if (it.tgt < cyc) compare({it.nm, "_missed"}, 8'hff, it.v);
            else compare(it.nm, act_word(), it.v);
         end
      end
   end

   // Shoot-through watch on every falling edge, including random and reset phases.
   initial begin
      forever begin
         @(negedge ACLK);
         if ((gate_ah && gate_al) || (gate_bh && gate_bl)) shoot_seen = 1'b1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation bound exceeded");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset
      tick(1);
      expect_at(1, "reset", S_IDLE, 4'b0000, 1'b0);
      tick(1);
      ARESET = 1'b0;
      enable = 1'b1;
      expect_at(1, "start_dead", S_DEAD, 4'b0000, 1'b0);
      expect_at(4, "start_dead_last", S_DEAD, 4'b0000, 1'b0);
      expect_at(5, "run_fwd_entry", S_FWD, 4'b0101, 1'b0);
      tick(5);

      // PWM rising edge in RUN_FWD
      pwm_in = 1'b1;
      expect_at(1, "rise_al_off", S_FWD, 4'b0001, 1'b0);
      expect_at(4, "rise_gap_end", S_FWD, 4'b0001, 1'b0);
      expect_at(5, "rise_ah_on", S_FWD, 4'b1001, 1'b0);
      tick(5);
      // Falling edge
      pwm_in = 1'b0;
      expect_at(1, "fall_ah_off", S_FWD, 4'b0001, 1'b0);
      expect_at(4, "fall_gap_end", S_FWD, 4'b0001, 1'b0);
      expect_at(5, "fall_al_on", S_FWD, 4'b0101, 1'b0);
      tick(5);
      // 2-cycle pulse never asserts ah
      pwm_in = 1'b1;
      for (int i = 1; i <= 6; i++) expect_at(i, "short_pulse_off", S_FWD, 4'b0001, 1'b0);
      expect_at(7, "short_pulse_al_back", S_FWD, 4'b0101, 1'b0);
      tick(2);
      pwm_in = 1'b0;
      tick(5);

      // Direction change: 4 all-off cycles then leg B follows pwm (high), al=1
      dir    = 1'b1;
      pwm_in = 1'b1;
      for (int i = 1; i <= 4; i++) expect_at(i, "dir_dead", S_DEAD, 4'b0000, 1'b0);
      expect_at(5, "run_rev_entry", S_REV, 4'b0110, 1'b0);
      tick(5);

      // Brake entry and exit
      brake = 1'b1;
      expect_at(1, "brake_dead", S_DEAD, 4'b0000, 1'b0);
      expect_at(4, "brake_dead_last", S_DEAD, 4'b0000, 1'b0);
      expect_at(5, "brake_on", S_BRK, 4'b0101, 1'b0);
      tick(5);
      brake = 1'b0;
      expect_at(1, "unbrake_dead", S_DEAD, 4'b0000, 1'b0);
      expect_at(5, "unbrake_rev", S_REV, 4'b0110, 1'b0);
      tick(5);

      // Enable drop and restore
      enable = 1'b0;
      expect_at(1, "disable_idle", S_IDLE, 4'b0000, 1'b0);
      tick(1);
      enable = 1'b1;
      expect_at(1, "reenable_dead", S_DEAD, 4'b0000, 1'b0);
      expect_at(5, "reenable_rev", S_REV, 4'b0110, 1'b0);
      tick(5);

      // One-cycle fault pulse: seen through 2 sync flops, gates off on the third edge
      fault_n = 1'b0;
      expect_at(2, "fault_still_run", S_REV, 4'b0110, 1'b0);
      expect_at(3, "fault_entry", S_FLT, 4'b0000, 1'b1);
      expect_at(6, "fault_held", S_FLT, 4'b0000, 1'b1);
      tick(1);
      fault_n = 1'b1;
      tick(5);

      // fault_clr ignored while fault is still present
      fault_n = 1'b0;
      tick(2);
      fault_clr = 1'b1;
      expect_at(1, "clr_ignored", S_FLT, 4'b0000, 1'b1);
      tick(1);
      fault_clr = 1'b0;
      fault_n   = 1'b1;
      tick(2);
      fault_clr = 1'b1;
      expect_at(1, "clr_to_idle", S_IDLE, 4'b0000, 1'b0);
      expect_at(2, "clr_restart", S_DEAD, 4'b0000, 1'b0);
      expect_at(6, "clr_rev", S_REV, 4'b0110, 1'b0);
      tick(1);
      fault_clr = 1'b0;
      tick(5);

      // Reset mid-run: gates drop without waiting for a clock edge
      ARESET = 1'b1;
      #1;
      compare("areset_async", act_word(), 8'h00);
      tick(1);
      ARESET = 1'b0;

      // Random stimulus under the shoot-through watch
      for (int i = 0; i < 400; i++) begin
         tick(1);
         enable    = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) dir = ~dir;
         if ($urandom_range(0, 19) == 0) brake = ~brake;
         if ($urandom_range(0, 4) == 0) pwm_in = ~pwm_in;
         fault_n   = ($urandom_range(0, 40) != 0);
         fault_clr = ($urandom_range(0, 7) == 0);
         if (i == 200) begin
            ARESET = 1'b1;
            #1;
            compare("areset_async_rand", {4'b0000, gate_ah, gate_al, gate_bh, gate_bl}, 8'h00);
            tick(1);
            ARESET = 1'b0;
         end
      end

      // Return to a known idle state
      tick(1);
      enable    = 1'b0;
      fault_n   = 1'b1;
      fault_clr = 1'b1;
      tick(4);
      expect_at(1, "idle_after_random", S_IDLE, 4'b0000, 1'b0);
      tick(2);
      fault_clr = 1'b0;

      for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
      compare("scoreboard_drained", 8'(sb.size()), 8'h00);
      compare("no_shoot_through", {7'b0, shoot_seen}, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
